// File: rtl/cpu_reg_bank_pkg.sv
// Shared constants, select encodings and word types for the 19-bit CPU register bank.
package cpu_reg_bank_pkg;

  localparam int unsigned WORD_SIZE     = 19;
  localparam int unsigned FLAG_REG_SIZE = 4;

  localparam int unsigned SEL_PC = 0;
  localparam int unsigned SEL_IR = 1;

  // Legacy fixed-bank codes; identical to gpr_sel(0..2).
  localparam int unsigned LOAD_REG_A = 2;
  localparam int unsigned LOAD_REG_B = 3;
  localparam int unsigned LOAD_REG_C = 4;

  typedef logic [WORD_SIZE-1:0]     word_t;
  typedef logic [FLAG_REG_SIZE-1:0] flags_t;

  function automatic int unsigned gpr_sel(input int unsigned k);
    return k + 2;
  endfunction

endpackage

// File: rtl/cpu_reg_read_mux.sv
// Select-to-data read mux for one register bank read port.
// Optional write-through bypass when REG_BANK_BYPASS_EN is defined.
module cpu_reg_read_mux
  import cpu_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = 19,
  parameter int unsigned NUM_GPR = 3,
  parameter int unsigned SEL_W   = 5
) (
  input  logic [SEL_W-1:0]               sel,
  input  logic [WIDTH-1:0]               pc,
  input  logic [WIDTH-1:0]               ir,
  input  logic [NUM_GPR-1:0][WIDTH-1:0]  gpr,
`ifdef REG_BANK_BYPASS_EN
  input  logic                           load_en,
  input  logic [SEL_W-1:0]               load_sel,
  input  logic [WIDTH-1:0]               load_data,
`endif
  output logic [WIDTH-1:0]               data
);

  localparam int unsigned NumSel = NUM_GPR + 2;

  always_comb begin
    data = '0;
    if (32'(sel) == SEL_PC) begin
      data = pc;
    end else if (32'(sel) == SEL_IR) begin
      data = ir;
    end else begin
      for (int unsigned k = 0; k < NUM_GPR; k++) begin
        if (32'(sel) == gpr_sel(k)) data = gpr[k];
      end
    end
`ifdef REG_BANK_BYPASS_EN
    // Write-through wins over stored state, including over a same-cycle pc_inc.
    if (load_en && (sel == load_sel) && (32'(load_sel) < NumSel)) data = load_data;
`endif
  end

endmodule

// File: rtl/cpu_reg_bank.sv
// Architectural register bank: PC with auto-increment, IR, NUM_GPR GPRs, flags, sticky sel_err.
// REG_BANK_BYPASS_EN enables write-through on the read ports.
module cpu_reg_bank
  import cpu_reg_bank_pkg::*;
#(
  parameter int unsigned WIDTH   = 19,
  parameter int unsigned NUM_GPR = 3,
  parameter int unsigned SEL_W   = 5,
  parameter int unsigned FLAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [SEL_W-1:0]  load_sel,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              pc_inc,
  input  logic              flag_we,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic [SEL_W-1:0]  rd_sel_a,
  input  logic [SEL_W-1:0]  rd_sel_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [WIDTH-1:0]  pc_out,
  output logic [WIDTH-1:0]  ir_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              sel_err,
  input  logic              err_clr
);

  localparam int unsigned NumSel = NUM_GPR + 2;

  logic [WIDTH-1:0]              pc_q, pc_d;
  logic [WIDTH-1:0]              ir_q, ir_d;
  logic [NUM_GPR-1:0][WIDTH-1:0] gpr_q, gpr_d;
  logic [FLAG_W-1:0]             flags_q, flags_d;
  logic                          sel_err_q, sel_err_d;
  logic                          load_legal;

  assign load_legal = 32'(load_sel) < NumSel;

  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    gpr_d     = gpr_q;
    flags_d   = flags_q;
    sel_err_d = sel_err_q;

    // A branch load beats the fetch increment.
    if (load_en && (32'(load_sel) == SEL_PC)) begin
      pc_d = load_data;
    end else if (pc_inc) begin
      pc_d = pc_q + WIDTH'(1);
    end

    if (load_en && (32'(load_sel) == SEL_IR)) ir_d = load_data;

    for (int unsigned k = 0; k < NUM_GPR; k++) begin
      if (load_en && (32'(load_sel) == gpr_sel(k))) gpr_d[k] = load_data;
    end

    if (flag_we) flags_d = flag_in;

    // A new illegal strobe wins over err_clr.
    if (load_en && !load_legal) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= '0;
      gpr_q     <= '0;
      flags_q   <= '0;
      sel_err_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      gpr_q     <= gpr_d;
      flags_q   <= flags_d;
      sel_err_q <= sel_err_d;
    end
  end

  cpu_reg_read_mux #(
    .WIDTH   (WIDTH),
    .NUM_GPR (NUM_GPR),
    .SEL_W   (SEL_W)
  ) u_read_mux_a (
    .sel       (rd_sel_a),
    .pc        (pc_q),
    .ir        (ir_q),
    .gpr       (gpr_q),
`ifdef REG_BANK_BYPASS_EN
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_data (load_data),
`endif
    .data      (rd_data_a)
  );

  cpu_reg_read_mux #(
    .WIDTH   (WIDTH),
    .NUM_GPR (NUM_GPR),
    .SEL_W   (SEL_W)
  ) u_read_mux_b (
    .sel       (rd_sel_b),
    .pc        (pc_q),
    .ir        (ir_q),
    .gpr       (gpr_q),
`ifdef REG_BANK_BYPASS_EN
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_data (load_data),
`endif
    .data      (rd_data_b)
  );

  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign flags_out = flags_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_cpu_reg_bank.sv
// Directed self-checking bench for cpu_reg_bank at default parameters.
module tb_cpu_reg_bank;

  localparam int unsigned WIDTH   = 19;
  localparam int unsigned NUM_GPR = 3;
  localparam int unsigned SEL_W   = 5;
  localparam int unsigned FLAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_en;
  logic [SEL_W-1:0]  load_sel;
  logic [WIDTH-1:0]  load_data;
  logic              pc_inc;
  logic              flag_we;
  logic [FLAG_W-1:0] flag_in;
  logic [SEL_W-1:0]  rd_sel_a;
  logic [SEL_W-1:0]  rd_sel_b;
  logic [WIDTH-1:0]  rd_data_a;
  logic [WIDTH-1:0]  rd_data_b;
  logic [WIDTH-1:0]  pc_out;
  logic [WIDTH-1:0]  ir_out;
  logic [FLAG_W-1:0] flags_out;
  logic              sel_err;
  logic              err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_reg_bank #(
    .WIDTH   (WIDTH),
    .NUM_GPR (NUM_GPR),
    .SEL_W   (SEL_W),
    .FLAG_W  (FLAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_data (load_data),
    .pc_inc    (pc_inc),
    .flag_we   (flag_we),
    .flag_in   (flag_in),
    .rd_sel_a  (rd_sel_a),
    .rd_sel_b  (rd_sel_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .pc_out    (pc_out),
    .ir_out    (ir_out),
    .flags_out (flags_out),
    .sel_err   (sel_err),
    .err_clr   (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are sampled before the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int sel, input logic [WIDTH-1:0] data);
    load_en   = 1'b1;
    load_sel  = SEL_W'(sel);
    load_data = data;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic rd_a(input int sel);
    rd_sel_a = SEL_W'(sel);
    #1;
  endtask

  task automatic rd_b(input int sel);
    rd_sel_b = SEL_W'(sel);
    #1;
  endtask

  initial begin
    rst = 1'b1; load_en = 1'b0; load_sel = '0; load_data = '0; pc_inc = 1'b0;
    flag_we = 1'b0; flag_in = '0; rd_sel_a = '0; rd_sel_b = '0; err_clr = 1'b0;
    tick();
    rst = 1'b0;

    // 1. Reset overrides everything, with all state preloaded non-zero
    load(0, 19'h00011);
    load(1, 19'h00022);
    load(2, 19'h00033);
    load(3, 19'h00044);
    load(4, 19'h00055);
    load(9, 19'h00066);
    flag_we = 1'b1; flag_in = 4'hF; tick(); flag_we = 1'b0;
    check("pre_sel_err", 32'(sel_err), 32'd1);
    rd_a(3);
    check("pre_gpr1", 32'(rd_data_a), 32'h44);
    rst = 1'b1; load_en = 1'b1; load_sel = 5'd2; load_data = 19'h7FFFF;
    pc_inc = 1'b1; flag_we = 1'b1; flag_in = 4'h5;
    tick();
    rst = 1'b0; load_en = 1'b0; pc_inc = 1'b0; flag_we = 1'b0;
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_ir", 32'(ir_out), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_sel_err", 32'(sel_err), 32'd0);
    rd_a(2); rd_b(3);
    check("rst_gpr0", 32'(rd_data_a), 32'd0);
    check("rst_gpr1", 32'(rd_data_b), 32'd0);
    rd_a(4);
    check("rst_gpr2", 32'(rd_data_a), 32'd0);

    // 2. Load and read back
    load(2, 19'h00111);
    load(3, 19'h00222);
    load(4, 19'h12345);
    rd_a(4);
    check("gpr2_rd", 32'(rd_data_a), 32'h12345);
    rd_a(2); rd_b(3);
    check("gpr0_kept", 32'(rd_data_a), 32'h00111);
    check("gpr1_kept", 32'(rd_data_b), 32'h00222);
    rd_b(2);
    check("same_reg_both", 32'(rd_data_b), 32'h00111);

    // 3. PC wrap and priority
    load(0, 19'h7FFFF);
    rd_a(0);
    check("pc_rd_port", 32'(rd_data_a), 32'h7FFFF);
    pc_inc = 1'b1; tick(); pc_inc = 1'b0;
    check("pc_wrap", 32'(pc_out), 32'd0);
    pc_inc = 1'b1; load_en = 1'b1; load_sel = 5'd0; load_data = 19'h00100;
    tick();
    load_en = 1'b0;
    check("pc_load_beats_inc", 32'(pc_out), 32'h00100);
    load_en = 1'b1; load_sel = 5'd1; load_data = 19'h0ABCD;
    tick();
    load_en = 1'b0; pc_inc = 1'b0;
    check("pc_inc_with_ir", 32'(pc_out), 32'h00101);
    check("ir_with_inc", 32'(ir_out), 32'h0ABCD);

    // 4. Illegal select
    load(5, 19'h07777);
    check("ill_sel_err", 32'(sel_err), 32'd1);
    check("ill_pc", 32'(pc_out), 32'h00101);
    check("ill_ir", 32'(ir_out), 32'h0ABCD);
    rd_a(2); rd_b(3);
    check("ill_gpr0", 32'(rd_data_a), 32'h00111);
    check("ill_gpr1", 32'(rd_data_b), 32'h00222);
    rd_a(4);
    check("ill_gpr2", 32'(rd_data_a), 32'h12345);
    tick();
    check("sel_err_sticky", 32'(sel_err), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("sel_err_clr", 32'(sel_err), 32'd0);
    err_clr = 1'b1; load(31, 19'h1); err_clr = 1'b0;
    check("sel_err_set_wins", 32'(sel_err), 32'd1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // 5. Bypass vs registered read
    load_en = 1'b1; load_sel = 5'd2; load_data = 19'h00AAA;
    rd_b(2);
`ifdef REG_BANK_BYPASS_EN
    check("byp_same_cycle", 32'(rd_data_b), 32'h00AAA);
`else
    check("nobyp_same_cycle", 32'(rd_data_b), 32'h00111);
`endif
    tick();
    load_en = 1'b0;
    #1;
    check("byp_next_cycle", 32'(rd_data_b), 32'h00AAA);
    load_en = 1'b1; load_sel = 5'd0; load_data = 19'h00555; pc_inc = 1'b1;
    rd_a(0);
`ifdef REG_BANK_BYPASS_EN
    check("byp_pc_rd", 32'(rd_data_a), 32'h00555);
`else
    check("nobyp_pc_rd", 32'(rd_data_a), 32'h00101);
`endif
    check("pc_out_not_byp", 32'(pc_out), 32'h00101);
    tick();
    load_en = 1'b0; pc_inc = 1'b0;
    check("pc_after_byp", 32'(pc_out), 32'h00555);

    // 6. Flags alongside an IR load; illegal read selects
    flag_we = 1'b1; flag_in = 4'b1010;
    load(1, 19'h3C3C3);
    flag_we = 1'b0;
    check("flags_upd", 32'(flags_out), 32'hA);
    check("ir_with_flags", 32'(ir_out), 32'h3C3C3);
    load(3, 19'h00BBB);
    check("flags_hold", 32'(flags_out), 32'hA);
    rd_a(7); rd_b(5);
    check("ill_rd_a", 32'(rd_data_a), 32'd0);
    check("ill_rd_b", 32'(rd_data_b), 32'd0);
    tick();
    check("ill_rd_no_err", 32'(sel_err), 32'd0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
